boot_loader_master: RTL

//  Bus initiator filling instruction RAM at boot: takes a byte stream (e.g. UART RX),

---
 rtl/boot_loader_master.sv | 122 ++++++++++++
 1 files changed

// File: rtl/boot_loader_master.sv
// boot_loader_master: streams a length-prefixed little-endian byte image into instruction RAM over the req/gnt/rvalid bus.
// Optional read-back XOR verification when BOOT_VERIFY_EN is defined.
module boot_loader_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic        boot_busy,
    output logic        boot_done,
    output logic        boot_err
);
    localparam int IW = $clog2(MAX_WORDS) + 1;
`ifdef BOOT_VERIFY_EN
    typedef enum logic [3:0] {IDLE, LEN, DATA, WGAP, WREQ, WRSP, VGAP, VREQ, VRSP, DONE, ERR} state_t;
`else
    typedef enum logic [3:0] {IDLE, LEN, DATA, WGAP, WREQ, WRSP, DONE, ERR} state_t;
`endif
    state_t        state, state_n;
    logic [1:0]    bcnt;
    logic [23:0]   sh;
    logic [31:0]   wdata_q;
    logic [IW-1:0] n, i;
    logic          err_q;
    logic          take, word_end, last, wr_fin, rd_fin, fin;
    logic [31:0]   full;
    state_t        wr_next, rd_next;
    assign take     = rx_valid && rx_ready;
    assign full     = {rx_data, sh};
    assign word_end = take && bcnt == 2'd3;
    assign last     = i + IW'(1) == n;
    assign wr_fin   = ((state == WREQ && bus_gnt) || state == WRSP) && bus_rvalid;
    assign fin      = wr_fin || rd_fin;
`ifdef BOOT_VERIFY_EN
    logic [31:0] xw, xr;
    assign rd_fin  = ((state == VREQ && bus_gnt) || state == VRSP) && bus_rvalid;
    assign wr_next = bus_err ? ERR : last ? VGAP : DATA;
    assign rd_next = bus_err || (last && (xr ^ bus_rdata) != xw) ? ERR : last ? DONE : VGAP;
    assign bus_req = state == WREQ || state == VREQ;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xw <= '0;
            xr <= '0;
        end else begin
            if (state == IDLE && boot_start) begin
                xw <= '0;
                xr <= '0;
            end
            if (word_end && state == DATA) xw <= xw ^ full;
            if (rd_fin) xr <= xr ^ bus_rdata;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^bus_rdata;
    assign rd_fin  = 1'b0;
    assign wr_next = bus_err ? ERR : last ? DONE : DATA;
    assign rd_next = IDLE;
    assign bus_req = state == WREQ;
`endif
    assign rx_ready  = state == LEN || state == DATA;
    assign bus_we    = state == WREQ;
    assign bus_addr  = bus_req ? BASE_ADDR + {{(30-IW){1'b0}}, i, 2'b00} : '0;
    assign bus_wdata = bus_we ? wdata_q : '0;
    assign bus_be    = 4'hF;
    assign boot_busy = !(state == IDLE || state == DONE || state == ERR);
    assign boot_done = state == DONE;
    assign boot_err  = err_q;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = boot_start ? LEN : IDLE;
            LEN:  if (word_end) state_n = full == 32'd0 ? DONE : full > 32'(MAX_WORDS) ? ERR : DATA;
            DATA: if (word_end) state_n = WGAP;
            WGAP: if (!bus_gnt) state_n = WREQ;
            WREQ: if (bus_gnt) state_n = bus_rvalid ? wr_next : WRSP;
            WRSP: if (bus_rvalid) state_n = wr_next;
`ifdef BOOT_VERIFY_EN
            VGAP: if (!bus_gnt) state_n = VREQ;
            VREQ: if (bus_gnt) state_n = bus_rvalid ? rd_next : VRSP;
            VRSP: if (bus_rvalid) state_n = rd_next;
`endif
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bcnt    <= '0;
            sh      <= '0;
            wdata_q <= '0;
            n       <= '0;
            i       <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (take) begin
                bcnt <= bcnt + 2'd1;
                sh   <= full[31:8];
            end
            if (word_end && state == LEN) n <= full[IW-1:0];
            if (word_end && state == DATA) wdata_q <= full;
            if (state == IDLE && boot_start) i <= '0;
            else if (fin) i <= last ? '0 : i + IW'(1);
            if (state_n == ERR) err_q <= 1'b1;
            else if (state == IDLE && boot_start) err_q <= 1'b0;
        end
    end
endmodule
